// File: rtl/reservation_station.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops both
// result buses for pending operands and issues the lowest-index ready entry per cycle.
module reservation_station #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             has_misbranch,
  input  logic             in_valid,
  input  logic [5:0]       in_op,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_shamt,
  input  logic [ROB_W-1:0] in_rd_robnum,
  input  logic             in_rs1_ready,
  input  logic [31:0]      in_rs1_val,
  input  logic [ROB_W-1:0] in_rs1_robnum,
  input  logic             in_rs2_ready,
  input  logic [31:0]      in_rs2_val,
  input  logic [ROB_W-1:0] in_rs2_robnum,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_robnum,
  input  logic [31:0]      alu_cdb_data,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_robnum,
  input  logic [31:0]      lsb_cdb_data,
  output logic             rs_full,
  output logic             has_to_alu,
  output logic [5:0]       op,
  output logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [4:0]       shamt,
  output logic [ROB_W-1:0] out_rd_robnum,
  output logic [31:0]      rs1_oprand,
  output logic [31:0]      rs2_oprand
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, r1_rdy_q, r2_rdy_q;
  logic [5:0]         op_q     [RS_SIZE];
  logic [31:0]        imm_q    [RS_SIZE];
  logic [31:0]        pc_q     [RS_SIZE];
  logic [4:0]         shamt_q  [RS_SIZE];
  logic [ROB_W-1:0]   rd_q     [RS_SIZE];
  logic [31:0]        r1_val_q [RS_SIZE];
  logic [31:0]        r2_val_q [RS_SIZE];
  logic [ROB_W-1:0]   r1_tag_q [RS_SIZE];
  logic [ROB_W-1:0]   r2_tag_q [RS_SIZE];

  logic [32:0]        r1_snoop [RS_SIZE];
  logic [32:0]        r2_snoop [RS_SIZE];
  logic [32:0]        in1_snoop, in2_snoop;
  logic               free_found, sel_found;
  logic [IdxW-1:0]    free_idx, sel_idx;

  // {hit, data}; the ALU bus wins when both carry the same tag
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0] tag);
    if (alu_cdb_valid && alu_cdb_robnum == tag) return {1'b1, alu_cdb_data};
    if (lsb_cdb_valid && lsb_cdb_robnum == tag) return {1'b1, lsb_cdb_data};
    return 33'd0;
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      r1_snoop[i] = snoop(r1_tag_q[i]);
      r2_snoop[i] = snoop(r2_tag_q[i]);
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (busy_q[i] && r1_rdy_q[i] && r2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
    in1_snoop = snoop(in_rs1_robnum);
    in2_snoop = snoop(in_rs2_robnum);
  end

  assign rs_full = &busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= '0;
      r1_rdy_q      <= '0;
      r2_rdy_q      <= '0;
      has_to_alu    <= 1'b0;
      op            <= '0;
      imm           <= '0;
      pc            <= '0;
      shamt         <= '0;
      out_rd_robnum <= '0;
      rs1_oprand    <= '0;
      rs2_oprand    <= '0;
    end else if (has_misbranch) begin
      busy_q     <= '0;
      has_to_alu <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !r1_rdy_q[i] && r1_snoop[i][32]) begin
          r1_rdy_q[i] <= 1'b1;
          r1_val_q[i] <= r1_snoop[i][31:0];
        end
        if (busy_q[i] && !r2_rdy_q[i] && r2_snoop[i][32]) begin
          r2_rdy_q[i] <= 1'b1;
          r2_val_q[i] <= r2_snoop[i][31:0];
        end
      end
      if (sel_found) begin
        has_to_alu      <= 1'b1;
        op              <= op_q[sel_idx];
        imm             <= imm_q[sel_idx];
        pc              <= pc_q[sel_idx];
        shamt           <= shamt_q[sel_idx];
        out_rd_robnum   <= rd_q[sel_idx];
        rs1_oprand      <= r1_val_q[sel_idx];
        rs2_oprand      <= r2_val_q[sel_idx];
        busy_q[sel_idx] <= 1'b0;
      end else begin
        has_to_alu <= 1'b0;
      end
      // The issuing slot is still busy here, so free_idx never collides with sel_idx
      if (in_valid && free_found) begin
        busy_q[free_idx]   <= 1'b1;
        op_q[free_idx]     <= in_op;
        imm_q[free_idx]    <= in_imm;
        pc_q[free_idx]     <= in_pc;
        shamt_q[free_idx]  <= in_shamt;
        rd_q[free_idx]     <= in_rd_robnum;
        r1_tag_q[free_idx] <= in_rs1_robnum;
        r2_tag_q[free_idx] <= in_rs2_robnum;
        r1_rdy_q[free_idx] <= in_rs1_ready | in1_snoop[32];
        r2_rdy_q[free_idx] <= in_rs2_ready | in2_snoop[32];
        r1_val_q[free_idx] <= in_rs1_ready ? in_rs1_val : in1_snoop[31:0];
        r2_val_q[free_idx] <= in_rs2_ready ? in_rs2_val : in2_snoop[31:0];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed plus randomized bench for reservation_station, checked against a
// behavioural entry-table model updated once per clock edge.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy, has_misbranch, in_valid;
  logic [5:0]  in_op;
  logic [31:0] in_imm, in_pc, in_rs1_val, in_rs2_val;
  logic [4:0]  in_shamt;
  logic [3:0]  in_rd_robnum, in_rs1_robnum, in_rs2_robnum;
  logic        in_rs1_ready, in_rs2_ready;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_robnum, lsb_cdb_robnum;
  logic [31:0] alu_cdb_data, lsb_cdb_data;
  logic        rs_full, has_to_alu;
  logic [5:0]  op;
  logic [31:0] imm, pc, rs1_oprand, rs2_oprand;
  logic [4:0]  shamt;
  logic [3:0]  out_rd_robnum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(8), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .in_valid(in_valid), .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc),
    .in_shamt(in_shamt), .in_rd_robnum(in_rd_robnum),
    .in_rs1_ready(in_rs1_ready), .in_rs1_val(in_rs1_val), .in_rs1_robnum(in_rs1_robnum),
    .in_rs2_ready(in_rs2_ready), .in_rs2_val(in_rs2_val), .in_rs2_robnum(in_rs2_robnum),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_robnum(alu_cdb_robnum),
    .alu_cdb_data(alu_cdb_data),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_robnum(lsb_cdb_robnum),
    .lsb_cdb_data(lsb_cdb_data),
    .rs_full(rs_full), .has_to_alu(has_to_alu), .op(op), .imm(imm), .pc(pc),
    .shamt(shamt), .out_rd_robnum(out_rd_robnum),
    .rs1_oprand(rs1_oprand), .rs2_oprand(rs2_oprand)
  );

  // Reference model: a table of waiting instructions plus the last issued one
  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] imm, pc, v1, v2;
    logic [4:0]  sh;
    logic [3:0]  rd, t1, t2;
    bit          r1, r2;
  } ent_t;

  ent_t        m [8];
  bit          e_hta;
  logic [5:0]  e_op;
  logic [31:0] e_imm, e_pc, e_rs1, e_rs2;
  logic [4:0]  e_sh;
  logic [3:0]  e_rd;

  function automatic bit cdb_hit(input logic [3:0] t, output logic [31:0] d);
    d = 32'd0;
    if (alu_cdb_valid && alu_cdb_robnum == t) begin d = alu_cdb_data; return 1'b1; end
    if (lsb_cdb_valid && lsb_cdb_robnum == t) begin d = lsb_cdb_data; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m[i].busy = 1'b0; m[i].r1 = 1'b0; m[i].r2 = 1'b0;
    end
    e_hta = 1'b0; e_op = '0; e_imm = '0; e_pc = '0; e_sh = '0; e_rd = '0;
    e_rs1 = '0; e_rs2 = '0;
  endtask

  task automatic model_step();
    ent_t        old [8];
    int          sel, slot;
    bit          full, hit;
    logic [31:0] d;
    if (has_misbranch) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      e_hta = 1'b0;
      return;
    end
    if (!rdy) return;
    old  = m;
    sel  = -1;
    slot = -1;
    full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (old[i].busy && old[i].r1 && old[i].r2 && sel < 0) sel = i;
      if (!old[i].busy) begin
        full = 1'b0;
        if (slot < 0) slot = i;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (old[i].busy && !old[i].r1) begin
        hit = cdb_hit(old[i].t1, d);
        if (hit) begin m[i].r1 = 1'b1; m[i].v1 = d; end
      end
      if (old[i].busy && !old[i].r2) begin
        hit = cdb_hit(old[i].t2, d);
        if (hit) begin m[i].r2 = 1'b1; m[i].v2 = d; end
      end
    end
    if (sel >= 0) begin
      e_hta = 1'b1;
      e_op = old[sel].op; e_imm = old[sel].imm; e_pc = old[sel].pc; e_sh = old[sel].sh;
      e_rd = old[sel].rd; e_rs1 = old[sel].v1; e_rs2 = old[sel].v2;
      m[sel].busy = 1'b0;
    end else begin
      e_hta = 1'b0;
    end
    if (in_valid && !full) begin
      m[slot].busy = 1'b1;
      m[slot].op = in_op; m[slot].imm = in_imm; m[slot].pc = in_pc;
      m[slot].sh = in_shamt; m[slot].rd = in_rd_robnum;
      m[slot].t1 = in_rs1_robnum; m[slot].t2 = in_rs2_robnum;
      hit = cdb_hit(in_rs1_robnum, d);
      m[slot].r1 = in_rs1_ready || hit;
      m[slot].v1 = in_rs1_ready ? in_rs1_val : d;
      hit = cdb_hit(in_rs2_robnum, d);
      m[slot].r2 = in_rs2_ready || hit;
      m[slot].v2 = in_rs2_ready ? in_rs2_val : d;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rs_full", 32'(rs_full), 32'(model_full()));
    chk("has_to_alu", 32'(has_to_alu), 32'(e_hta));
    chk("op", 32'(op), 32'(e_op));
    chk("imm", imm, e_imm);
    chk("pc", pc, e_pc);
    chk("shamt", 32'(shamt), 32'(e_sh));
    chk("out_rd_robnum", 32'(out_rd_robnum), 32'(e_rd));
    chk("rs1_oprand", rs1_oprand, e_rs1);
    chk("rs2_oprand", rs2_oprand, e_rs2);
  endtask

  task automatic idle();
    rdy = 1'b1; has_misbranch = 1'b0; in_valid = 1'b0;
    in_op = '0; in_imm = '0; in_pc = '0; in_shamt = '0; in_rd_robnum = '0;
    in_rs1_ready = 1'b0; in_rs1_val = '0; in_rs1_robnum = '0;
    in_rs2_ready = 1'b0; in_rs2_val = '0; in_rs2_robnum = '0;
    alu_cdb_valid = 1'b0; alu_cdb_robnum = '0; alu_cdb_data = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_robnum = '0; lsb_cdb_data = '0;
  endtask

  task automatic disp(input logic [5:0] o, input logic [3:0] rd,
                      input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [3:0] t2);
    in_valid = 1'b1; in_op = o; in_rd_robnum = rd;
    in_imm = {16'hA5A5, 12'h0, rd}; in_pc = 32'h1000 + {26'h0, o}; in_shamt = {1'b0, rd};
    in_rs1_ready = r1; in_rs1_val = v1; in_rs1_robnum = t1;
    in_rs2_ready = r2; in_rs2_val = v2; in_rs2_robnum = t2;
  endtask

  // One clock edge: advance the model, check after the edge, clear inputs
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Ready dispatch: add 5 + 7 -> rd 3
    disp(6'h01, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    step();
    step();
    step();

    // Wakeup via load bus, then dispatch-cycle snoop
    disp(6'h02, 4'd4, 1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0);
    step();
    lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd6; lsb_cdb_data = 32'h1234;
    step();
    step();
    step();
    disp(6'h03, 4'd5, 1'b0, 32'd0, 4'd6, 1'b1, 32'd2, 4'd0);
    lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd6; lsb_cdb_data = 32'h5678;
    step();
    step();
    step();

    // Fill, drop a 9th dispatch, then drain in index order
    for (int i = 0; i < 8; i++) begin
      disp(6'(i + 8), 4'(i), 1'b0, 32'd0, 4'd9, 1'b1, 32'(i * 3), 4'd0);
      step();
    end
    disp(6'h3f, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    step();
    alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd9; alu_cdb_data = 32'hCAFE_0009;
    step();
    repeat (9) step();

    // Flush with four waiting entries and a concurrent dispatch
    for (int i = 0; i < 4; i++) begin
      disp(6'h10, 4'(i), 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0);
      step();
    end
    disp(6'h11, 4'd7, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0);
    has_misbranch = 1'b1;
    step();
    alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd2; alu_cdb_data = 32'd22;
    step();
    repeat (3) step();

    // Stall while an issue is presented
    disp(6'h20, 4'd1, 1'b1, 32'd11, 4'd0, 1'b1, 32'd12, 4'd0);
    step();
    disp(6'h21, 4'd2, 1'b1, 32'd21, 4'd0, 1'b1, 32'd22, 4'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0;
      step();
    end
    step();
    step();

    // Asynchronous reset with three busy entries
    for (int i = 0; i < 3; i++) begin
      disp(6'h30, 4'(i), 1'b0, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0);
      step();
    end
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 1'b1;
    alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd13; alu_cdb_data = 32'd1;
    step();
    repeat (3) step();

    // Randomized traffic over a small tag space to provoke frequent matches
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 60 && (!model_full() || $urandom_range(0, 3) == 0))
        disp(6'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 3)));
      alu_cdb_valid = 1'($urandom_range(0, 2) == 0);
      alu_cdb_robnum = 4'($urandom_range(0, 3));
      alu_cdb_data = $urandom;
      lsb_cdb_valid = 1'($urandom_range(0, 2) == 0);
      lsb_cdb_robnum = 4'($urandom_range(0, 3));
      lsb_cdb_data = $urandom;
      rdy = 1'($urandom_range(0, 99) < 85);
      has_misbranch = 1'($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order reservation station for the integer ALU. It sits between dispatch and `alu`. It holds decoded ALU/branch/jump instructions until both source operands are available. It snoops the two result broadcast buses (ALU and load/store) to capture pending operands, then issues one ready instruction per cycle on the ALU input port. A mispredicted branch flushes every entry.

## Interface
Parameters:
- `RS_SIZE`, 8 — number of entries.
- `ROB_W`, 4 — ROB tag width.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `rdy`  in  1  — global enable; when low, all state and outputs hold.
- `has_misbranch`  in  1  — flush request.
- `in_valid`  in  1  — dispatch of one instruction this cycle.
- `in_op`  in  6  — ALU opcode.
- `in_imm`  in  32  — immediate.
- `in_pc`  in  32  — instruction PC.
- `in_shamt`  in  5  — shift amount.
- `in_rd_robnum`  in  ROB_W  — destination ROB tag.
- `in_rs1_ready`  in  1  — rs1 value valid.
- `in_rs1_val`  in  32  — rs1 value.
- `in_rs1_robnum`  in  ROB_W  — rs1 producer tag when not ready.
- `in_rs2_ready`  in  1  — rs2 value valid. Dispatch drives 1 for ops without rs2.
- `in_rs2_val`  in  32  — rs2 value.
- `in_rs2_robnum`  in  ROB_W  — rs2 producer tag.
- `alu_cdb_valid`, `alu_cdb_robnum`, `alu_cdb_data`  in  1/ROB_W/32  — ALU result broadcast.
- `lsb_cdb_valid`, `lsb_cdb_robnum`, `lsb_cdb_data`  in  1/ROB_W/32  — load result broadcast.
- `rs_full`  out  1  — no free entry.
- `has_to_alu`  out  1  — issue valid (one-cycle pulse).
- `op`  out  6  — issued opcode.
- `imm`  out  32  — issued immediate.
- `pc`  out  32  — issued PC.
- `shamt`  out  5  — issued shift amount.
- `out_rd_robnum`  out  ROB_W  — issued destination tag.
- `rs1_oprand`  out  32  — issued rs1 value.
- `rs2_oprand`  out  32  — issued rs2 value.

## Operation
- Each entry holds: busy, op, imm, pc, shamt, rd tag, and per-operand ready/value/tag.
- **Dispatch.** When `in_valid` and `!rs_full`, write into the lowest-index free entry. `in_valid` while `rs_full` is ignored; dispatch must not do this.
- **Dispatch-cycle snoop.** A not-ready dispatched operand whose tag matches a CDB broadcast in the same cycle is stored as ready with that CDB's data.
- **Wakeup.** Every busy entry with a not-ready operand whose tag equals a valid CDB tag captures the data and sets ready. Both CDBs are checked, for both operands, in every entry. If both CDBs carry the same tag, ALU data wins.
- **Select.** Among busy entries whose ready bits are both set (pre-edge state, so no same-cycle wakeup bypass), take the lowest index. Register its fields onto the issue outputs, set `has_to_alu`=1, and clear busy.
- **No ready entry.** `has_to_alu`=0; the other issue outputs hold their last values.
- **`rs_full`** is combinational: 1 when all entries are busy (pre-edge). It does not anticipate the same-cycle issue.
- **Flush.** `has_misbranch`=1 at an edge clears every busy bit and `has_to_alu`, and discards that cycle's dispatch. Flush acts even when `rdy`=0.
- **Stall.** `rdy`=0 without flush: nothing changes and `has_to_alu` holds, so the ALU sees an unchanged request once `rdy` returns.
- **Reset** (`rst`=0, asynchronous): all busy and ready bits = 0, `has_to_alu`=0, every data output = 0, `rs_full`=0.

## Timing
- Dispatch with both operands ready at edge N makes the entry eligible in cycle N+1; `has_to_alu`=1 after edge N+1.
- A CDB broadcast sampled at edge M readies the operand after M; issue occurs no earlier than edge M+1.
- Throughput: one issue per cycle, one dispatch per cycle, concurrently.
- Dispatch and issue in the same cycle: the issued slot is still busy, so dispatch takes another free slot.
- Priority at an edge: reset > flush > `rdy`-gated update.

## Test plan
- **Reset.** Drive `rst`=0 mid-run with 3 busy entries → `has_to_alu`=0 and `rs_full`=0 immediately; after release, no issue occurs without dispatch.
- **Ready dispatch.** Dispatch op_add, rs1=5, rs2=7, both ready, rd tag 3 at edge N → after N+1: `has_to_alu`=1, `rs1_oprand`=5, `rs2_oprand`=7, `out_rd_robnum`=3. After N+2: `has_to_alu`=0.
- **Wakeup.** Dispatch rs1 waiting on tag 6. Broadcast `lsb_cdb` tag 6 data 0x1234 at edge M → issue at edge M+1 with `rs1_oprand`=0x1234. Also broadcast tag 6 in the dispatch cycle itself → issue at the following edge.
- **Full.** Fill 8 entries, all waiting on tag 9 → `rs_full`=1 and a 9th `in_valid` is dropped. Broadcast tag 9 → entries issue in index order 0..7 on 8 consecutive edges.
- **Flush.** With 4 busy entries, pulse `has_misbranch` alongside a dispatch → no issue ever follows; `rs_full`=0.
- **Stall.** Set `rdy`=0 while `has_to_alu`=1 for 3 cycles → outputs unchanged. Raise `rdy` → the next ready entry issues at the next edge.
